// File: rtl/csum_engine_if.sv
// rtl/csum_engine_if.sv - single-port SRAM bus shared by csum_engine and its memory (ce/we/addr/sel/data)
interface csum_engine_if #(
  parameter int ADDR_W = 32
) ();
  logic              sram_ce_o;
  logic              sram_we_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [3:0]        sram_sel_o;
  logic [31:0]       sram_data_o;
  logic [31:0]       sram_data_i;

  modport master (
    output sram_ce_o, sram_we_o, sram_addr_o, sram_sel_o, sram_data_o,
    input  sram_data_i
  );

  modport slave (
    input  sram_ce_o, sram_we_o, sram_addr_o, sram_sel_o, sram_data_o,
    output sram_data_i
  );
endinterface

// File: rtl/csum_engine.sv
// rtl/csum_engine.sv - ones'-complement header checksum verify/insert engine over the SRAM bus
// Optional saturating VERIFY-failure counter built only when CSUM_ERRCNT_EN is defined.
module csum_engine #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 15,
  parameter int CSUM_WORD = 2,
  parameter int CSUM_HI   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [3:0]        hdr_words_i,
  input  logic              mode_i,
  csum_engine_if.master     sram,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       csum_o,
  output logic              csum_ok_o,
  output logic              err_o,
  output logic [15:0]       err_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DRAIN, S_FOLD, S_WRITE, S_DONE
  } state_t;

  localparam logic [4:0] LP_MAX = 5'(MAX_WORDS);
  localparam logic [4:0] LP_CW5 = 5'(CSUM_WORD);
  localparam logic [3:0] LP_CW4 = 4'(CSUM_WORD);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_n;
  logic              r_mode;
  logic [3:0]        r_cnt;
  logic              r_rd_vld;
  logic [3:0]        r_rd_idx;
  logic [20:0]       r_acc;
  logic [15:0]       r_csum;
  logic              r_ok;
  logic              r_err;

  logic              w_bad;
  logic              w_mask;
  logic [15:0]       w_hi;
  logic [15:0]       w_lo;
  logic [16:0]       w_f1;
  logic [15:0]       w_s;
  logic [3:0]        w_last;

  assign w_bad  = (hdr_words_i == 4'd0) || ({1'b0, hdr_words_i} > LP_MAX) ||
                  (mode_i && ({1'b0, hdr_words_i} <= LP_CW5));
  assign w_last = r_n - 4'd1;

  // INSERT ignores whatever currently sits in the checksum field
  assign w_mask = r_mode && (r_rd_idx == LP_CW4);
  assign w_hi   = (w_mask && (CSUM_HI != 0)) ? 16'h0 : sram.sram_data_i[31:16];
  assign w_lo   = (w_mask && (CSUM_HI == 0)) ? 16'h0 : sram.sram_data_i[15:0];

  assign w_f1 = {1'b0, r_acc[15:0]} + {12'd0, r_acc[20:16]};
  assign w_s  = w_f1[15:0] + {15'd0, w_f1[16]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt       = r_state;
    sram.sram_ce_o    = 1'b0;
    sram.sram_we_o    = 1'b0;
    sram.sram_addr_o  = '0;
    sram.sram_sel_o   = 4'h0;
    sram.sram_data_o  = 32'h0;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = w_bad ? S_DONE : S_READ;
      S_READ: begin
        sram.sram_ce_o   = 1'b1;
        sram.sram_sel_o  = 4'hF;
        sram.sram_addr_o = r_addr + {{(ADDR_W-6){1'b0}}, r_cnt, 2'b00};
        if (r_cnt == w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: w_state_nxt = S_FOLD;
      S_FOLD:  w_state_nxt = r_mode ? S_WRITE : S_DONE;
      S_WRITE: begin
        sram.sram_ce_o   = 1'b1;
        sram.sram_we_o   = 1'b1;
        sram.sram_addr_o = r_addr + ADDR_W'(4 * CSUM_WORD);
        sram.sram_sel_o  = (CSUM_HI != 0) ? 4'b1100 : 4'b0011;
        sram.sram_data_o = (CSUM_HI != 0) ? {r_csum, 16'h0} : {16'h0, r_csum};
        w_state_nxt      = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr   <= '0;
      r_n      <= 4'd0;
      r_mode   <= 1'b0;
      r_cnt    <= 4'd0;
      r_rd_vld <= 1'b0;
      r_rd_idx <= 4'd0;
      r_acc    <= 21'd0;
      r_csum   <= 16'h0;
      r_ok     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rd_vld <= (r_state == S_READ);
      r_rd_idx <= r_cnt;
      if (r_state == S_IDLE && start_i) begin
        r_addr <= start_addr_i;
        r_n    <= hdr_words_i;
        r_mode <= mode_i;
        r_cnt  <= 4'd0;
        r_acc  <= 21'd0;
        r_csum <= 16'h0;
        r_ok   <= 1'b0;
        r_err  <= w_bad;
      end
      if (r_state == S_READ) r_cnt <= r_cnt + 4'd1;
      if (r_rd_vld) r_acc <= r_acc + {5'd0, w_hi} + {5'd0, w_lo};
      if (r_state == S_FOLD) begin
        r_csum <= ~w_s;
        r_ok   <= !r_mode && (w_s == 16'hFFFF);
      end
    end
  end

  assign busy_o    = (r_state != S_IDLE);
  assign done_o    = (r_state == S_DONE);
  assign csum_o    = r_csum;
  assign csum_ok_o = r_ok;
  assign err_o     = r_err;

`ifdef CSUM_ERRCNT_EN
  logic [15:0] r_err_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err_cnt <= 16'h0;
    else if (r_state == S_DONE && !r_mode && !r_ok && r_err_cnt != 16'hFFFF)
      r_err_cnt <= r_err_cnt + 16'd1;
  end
  assign err_cnt_o = r_err_cnt;
`else
  assign err_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_csum_engine.sv
// tb/tb_csum_engine.sv - self-checking bench for csum_engine with an SRAM model and checksum reference
module tb_csum_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] start_addr_i = '0;
  logic [3:0]  hdr_words_i = '0;
  logic        mode_i = 1'b0;
  logic        busy_o, done_o, csum_ok_o, err_o;
  logic [15:0] csum_o, err_cnt_o;

  csum_engine_if #(.ADDR_W(32)) bus ();

  csum_engine dut (
    .clk(clk), .rst(rst), .start_i(start_i), .start_addr_i(start_addr_i),
    .hdr_words_i(hdr_words_i), .mode_i(mode_i), .sram(bus),
    .busy_o(busy_o), .done_o(done_o), .csum_o(csum_o), .csum_ok_o(csum_ok_o),
    .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [31:0] rdata = '0;
  int cyc = 0;
  int total = 0, bad = 0;
  int wr_cnt = 0, ce_cnt = 0, busy_cnt = 0, wr_cyc = 0;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_sel;
  int exp_cnt = 0;

  assign bus.sram_data_i = rdata;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.sram_ce_o && !bus.sram_we_o) rdata <= mem[bus.sram_addr_o[9:2]];
    if (bus.sram_ce_o && bus.sram_we_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.sram_sel_o[b]) mem[bus.sram_addr_o[9:2]][8*b +: 8] = bus.sram_data_o[8*b +: 8];
    end
  end

  always @(negedge clk) begin
    if (busy_o) busy_cnt++;
    if (bus.sram_ce_o) ce_cnt++;
    if (bus.sram_ce_o && bus.sram_we_o) begin
      wr_cnt++;
      wr_addr = bus.sram_addr_o;
      wr_sel  = bus.sram_sel_o;
      wr_data = bus.sram_data_o;
      wr_cyc  = cyc;
    end
  end

  // Ones'-complement sum of all 16-bit halves, field word's low half zeroed when masked
  function automatic logic [15:0] ones_sum(int base, int n, bit masked);
    int unsigned s = 0;
    for (int k = 0; k < n; k++) begin
      s += mem[base + k][31:16];
      if (!(masked && k == 2)) s += mem[base + k][15:0];
    end
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  function automatic logic [15:0] want_errcnt();
`ifdef CSUM_ERRCNT_EN
    return exp_cnt[15:0];
`else
    return 16'h0;
`endif
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [3:0] n, input logic m,
                       output int t0, output int dc);
    @(negedge clk);
    wr_cnt = 0; ce_cnt = 0; busy_cnt = 0;
    start_addr_i = a; hdr_words_i = n; mode_i = m; start_i = 1'b1;
    t0 = cyc;
    dc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (done_o) begin dc = cyc; break; end
    end
    @(negedge clk);
  endtask

  task automatic load_header();
    mem[16] = 32'h45000073; mem[17] = 32'h00004000; mem[18] = 32'h4011FFFF;
    mem[19] = 32'hC0A80001; mem[20] = 32'hC0A800C7;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({busy_o, done_o, csum_ok_o, err_o} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {busy_o, done_o, csum_ok_o, err_o}); end
    total++; if ({csum_o, err_cnt_o} !== 32'h0) begin bad++; $display("FAIL reset_values got=%h want=0", {csum_o, err_cnt_o}); end
    total++; if ({bus.sram_ce_o, bus.sram_we_o, bus.sram_sel_o} !== 6'b0 || bus.sram_addr_o !== 32'h0 || bus.sram_data_o !== 32'h0) begin
      bad++; $display("FAIL reset_bus ce=%b we=%b addr=%h sel=%h data=%h want all 0", bus.sram_ce_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_sel_o, bus.sram_data_o); end
    rst = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
  endtask

  task automatic test_insert();
    int t0, dc;
    do_op(32'd64, 4'd5, 1'b1, t0, dc);
    total++; if (dc !== t0 + 9) begin bad++; $display("FAIL ins_done_cycle got=%0d want=%0d", dc - t0, 9); end
    total++; if (wr_cnt !== 1) begin bad++; $display("FAIL ins_write_count got=%0d want=1", wr_cnt); end
    total++; if (wr_cyc !== t0 + 8) begin bad++; $display("FAIL ins_write_cycle got=%0d want=8", wr_cyc - t0); end
    total++; if (wr_addr !== 32'd72 || wr_sel !== 4'b0011 || wr_data !== 32'h0000B861) begin
      bad++; $display("FAIL ins_write got addr=%0d sel=%b data=%h want 72 0011 0000B861", wr_addr, wr_sel, wr_data); end
    total++; if (csum_o !== 16'hB861 || err_o !== 1'b0) begin bad++; $display("FAIL ins_csum got=%h err=%b want=B861 err=0", csum_o, err_o); end
    total++; if (busy_cnt !== 9) begin bad++; $display("FAIL ins_busy_cycles got=%0d want=9", busy_cnt); end
  endtask

  task automatic test_verify();
    int t0, dc;
    do_op(32'd64, 4'd5, 1'b0, t0, dc);
    total++; if (dc !== t0 + 8) begin bad++; $display("FAIL ver_done_cycle got=%0d want=8", dc - t0); end
    total++; if (wr_cnt !== 0 || ce_cnt !== 5) begin bad++; $display("FAIL ver_bus got writes=%0d ce=%0d want 0 5", wr_cnt, ce_cnt); end
    total++; if (csum_ok_o !== 1'b1 || csum_o !== 16'h0000) begin bad++; $display("FAIL ver_result got ok=%b csum=%h want 1 0000", csum_ok_o, csum_o); end
  endtask

  task automatic test_verify_bad();
    int t0, dc;
    logic [15:0] s;
    mem[20] = 32'hC0A800C8;
    s = ones_sum(16, 5, 1'b0);
    do_op(32'd64, 4'd5, 1'b0, t0, dc);
    exp_cnt++;
    total++; if (csum_ok_o !== 1'b0 || csum_o !== ~s) begin bad++; $display("FAIL verbad_result got ok=%b csum=%h want 0 %h", csum_ok_o, csum_o, ~s); end
    total++; if (err_cnt_o !== want_errcnt()) begin bad++; $display("FAIL verbad_errcnt got=%0d want=%0d", err_cnt_o, want_errcnt()); end
    mem[20] = 32'hC0A800C7;
  endtask

  task automatic test_errors();
    logic [3:0] ns [4] = '{4'd0, 4'd0, 4'd2, 4'd1};
    logic       ms [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    int t0, dc;
    for (int i = 0; i < 4; i++) begin
      do_op(32'd64, ns[i], ms[i], t0, dc);
      if (!ms[i]) exp_cnt++;
      total++; if (err_o !== 1'b1 || dc !== t0 + 1) begin bad++; $display("FAIL err_%0d got err=%b done_at=%0d want 1 1", i, err_o, dc - t0); end
      total++; if (ce_cnt !== 0 || csum_o !== 16'h0 || csum_ok_o !== 1'b0) begin
        bad++; $display("FAIL err_bus_%0d got ce=%0d csum=%h ok=%b want 0 0 0", i, ce_cnt, csum_o, csum_ok_o); end
      total++; if (busy_cnt !== 1 || err_cnt_o !== want_errcnt()) begin
        bad++; $display("FAIL err_busy_%0d got busy=%0d cnt=%0d want 1 %0d", i, busy_cnt, err_cnt_o, want_errcnt()); end
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    @(negedge clk);
    wr_cnt = 0;
    start_addr_i = 32'd64; hdr_words_i = 4'd5; mode_i = 1'b1; start_i = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 10 && cyc != t0 + 3; i++) @(negedge clk);
    total++; if (bus.sram_ce_o !== 1'b1) begin bad++; $display("FAIL rstmid_in_read got ce=%b want 1", bus.sram_ce_o); end
    rst = 1'b0;
    #1;
    total++; if ({busy_o, done_o, csum_ok_o, err_o, bus.sram_ce_o, bus.sram_we_o} !== 6'b0 || bus.sram_addr_o !== 32'h0 || bus.sram_sel_o !== 4'h0) begin
      bad++; $display("FAIL rstmid_outputs got busy=%b done=%b ce=%b we=%b addr=%h sel=%h want all 0", busy_o, done_o, bus.sram_ce_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_sel_o); end
    total++; if (csum_o !== 16'h0 || err_cnt_o !== 16'h0) begin bad++; $display("FAIL rstmid_values got csum=%h cnt=%h want 0 0", csum_o, err_cnt_o); end
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 0;
    repeat (12) @(negedge clk);
    total++; if (wr_cnt !== 0 || busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_aborted got writes=%0d busy=%b want 0 0", wr_cnt, busy_o); end
    test_insert();
  endtask

  task automatic test_start_held();
    int t0, d1, d2;
    @(negedge clk);
    wr_cnt = 0;
    start_addr_i = 32'd64; hdr_words_i = 4'd5; mode_i = 1'b1; start_i = 1'b1;
    t0 = cyc; d1 = -1; d2 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) begin d1 = cyc; break; end
    end
    total++; if (d1 !== t0 + 9 || wr_cnt !== 1) begin bad++; $display("FAIL held_first got done_at=%0d writes=%0d want 9 1", d1 - t0, wr_cnt); end
    @(negedge clk);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL held_gap got busy=%b want 0", busy_o); end
    @(negedge clk);
    start_i = 1'b0;
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL held_reaccept got busy=%b want 1", busy_o); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) begin d2 = cyc; break; end
    end
    @(negedge clk);
    total++; if (d2 !== t0 + 19 || wr_cnt !== 2) begin bad++; $display("FAIL held_second got done_at=%0d writes=%0d want 19 2", d2 - t0, wr_cnt); end
  endtask

  task automatic test_random();
    int t0, dc, base, n;
    logic m;
    logic [15:0] s;
    for (int it = 0; it < 24; it++) begin
      m = 1'($urandom_range(0, 1));
      n = m ? $urandom_range(3, 15) : $urandom_range(1, 15);
      base = $urandom_range(100, 230);
      for (int k = 0; k < n; k++) mem[base + k] = $urandom;
      if (!m && n >= 3 && $urandom_range(0, 1) == 1)
        mem[base + 2][15:0] = ~ones_sum(base, n, 1'b1);
      s = ones_sum(base, n, m);
      do_op(32'(base * 4), 4'(n), m, t0, dc);
      if (!m && s != 16'hFFFF) exp_cnt++;
      total++; if (csum_o !== ~s || err_o !== 1'b0) begin bad++; $display("FAIL rnd%0d_csum got=%h err=%b want=%h 0", it, csum_o, err_o, ~s); end
      total++; if (dc !== t0 + n + (m ? 4 : 3)) begin bad++; $display("FAIL rnd%0d_done got=%0d want=%0d", it, dc - t0, n + (m ? 4 : 3)); end
      total++; if (ce_cnt !== n + (m ? 1 : 0) || wr_cnt !== (m ? 1 : 0)) begin
        bad++; $display("FAIL rnd%0d_bus got ce=%0d wr=%0d want %0d %0d", it, ce_cnt, wr_cnt, n + (m ? 1 : 0), m ? 1 : 0); end
      if (m) begin
        total++; if (wr_addr !== 32'(base * 4 + 8) || wr_sel !== 4'b0011 || wr_data !== {16'h0, ~s} || wr_cyc !== t0 + n + 3) begin
          bad++; $display("FAIL rnd%0d_write got addr=%h sel=%b data=%h at=%0d", it, wr_addr, wr_sel, wr_data, wr_cyc - t0); end
      end else begin
        total++; if (csum_ok_o !== (s == 16'hFFFF)) begin bad++; $display("FAIL rnd%0d_ok got=%b want=%b", it, csum_ok_o, s == 16'hFFFF); end
      end
      total++; if (err_cnt_o !== want_errcnt()) begin bad++; $display("FAIL rnd%0d_errcnt got=%0d want=%0d", it, err_cnt_o, want_errcnt()); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    load_header();
    test_reset();
    test_insert();
    test_verify();
    test_verify_bad();
    test_errors();
    test_reset_mid();
    test_start_held();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1);
  end
endmodule
